instruction_sequencer: RTL
==========================

# instruction_sequencer

Fetch/execute controller for the instruction ROM. It drives the ROM address, registers the returned 28-bit instruction and decodes the opcode (NOP, STO, VGA, JMP, LED). It then sequences the side effects: timed delays, register-file writes, VGA draw requests with a valid/ready handshake, jumps and LED updates. It sits between the ROM and the register file / VGA draw engine and is the only source of the ROM address.

## Interface
- No parameters. Widths are fixed by the instruction format: 4-bit opcode, 8-bit field A, 16-bit field B; VGA uses color[23:16], regA[15:8], regB[7:0].
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; clears all state immediately.
- iEnable  in  1  run enable; sampled only in FETCH.
- iInstruction  in  28  combinational ROM data for oAddress.
- oAddress  out  16  ROM address, equal to the PC.
- oRegWrite  out  1  one-cycle register-file write strobe.
- oRegAddr  out  8  register index (instruction[23:16]).
- oRegData  out  16  immediate (instruction[15:0]).
- oVgaValid  out  1  draw request pending.
- iVgaReady  in  1  draw engine accepts the request.
- oVgaColor  out  8  draw color.
- oVgaRegA  out  8  first operand register index.
- oVgaRegB  out  8  second operand register index.
- oLed  out  8  LED latch.

## Operation
- Reset values: PC=0, IR=0, delay counter=0, state FETCH. oRegWrite=0, oVgaValid=0, oLed=0, all other outputs 0.
- States: FETCH, DECODE, WAIT_NOP, WAIT_VGA.
- FETCH:
  - oAddress=PC.
  - If iEnable=1: IR <= iInstruction, go to DECODE.
  - If iEnable=0: stay in FETCH; IR is unchanged.
- DECODE, by IR[27:24]:
  - NOP: counter <= IR[23:0]. If the value is 0: PC+1, go to FETCH. Otherwise go to WAIT_NOP.
  - STO: oRegWrite=1 for this cycle only; PC+1; go to FETCH.
  - VGA: oVgaValid=1 and operand fields driven from IR. If iVgaReady=1 this cycle: PC+1, go to FETCH. Otherwise go to WAIT_VGA.
  - JMP: PC <= IR[15:0]; go to FETCH.
  - LED: oLed <= IR[7:0]; PC+1; go to FETCH.
  - Any undefined opcode: behaves as NOP 0.
- WAIT_NOP: decrement the counter each cycle. When the counter reaches 1, PC+1 and go to FETCH.
- WAIT_VGA:
  - oVgaValid held at 1; operands held stable.
  - On iVgaReady=1: PC+1, go to FETCH.
- PC increment is modulo 2^16; 16'hFFFF increments to 0.
- JMP to its own address is a legal infinite loop.
- Wait states are not aborted by iEnable. Only Reset aborts them.
- Reset mid-WAIT_VGA drops oVgaValid asynchronously. The draw engine must treat that as a cancelled request.

## Timing
- The ROM is combinational, so instruction data is captured in the same FETCH cycle.
- Instruction cost, with iEnable=1:
  - STO, JMP, LED: 2 cycles.
  - NOP N: 2+N cycles.
  - VGA: 1 cycle + 1 + k, where k is the number of cycles oVgaValid is high before iVgaReady is seen.
- oRegWrite, oRegAddr and oRegData are registered outputs. They are valid in the cycle after DECODE begins and are consistent with each other in that cycle.
- Handshake transfer occurs on a rising edge where oVgaValid=1 and iVgaReady=1. oVgaValid is deasserted in the following cycle.
- oLed updates one cycle after DECODE of LED and holds until the next LED instruction or Reset.

## Structure
- Shared definitions include provides:
  - opcode constants for NOP, STO, VGA, JMP, LED;
  - register-index and color constants;
  - the field-position constants;
  - the state encoding as localparams.
- A single sub-module, delay_counter, is natural: a 24-bit loadable down-counter with a done flag.
- The sequencer FSM, PC and IR live in the top module.

## Test plan
- Reset release with iEnable=1 and ROM[0] = LED 8'hAA, ROM[1] = JMP 0 -> oLed=8'hAA by cycle 3. oAddress alternates 0,0,1,1,0,0…
- ROM[0] = NOP 24'd4000 -> oAddress stays 0 for 4002 cycles, then becomes 1.
- ROM[0] = STO R4,240 -> exactly one oRegWrite pulse with oRegAddr=R4 and oRegData=240; no second pulse.
- VGA GREEN,R4,R1 with iVgaReady held low for 5 cycles -> oVgaValid high for 6 cycles with stable operands; PC advances only after the transfer.
- iEnable=0 during FETCH for 10 cycles -> no strobes and PC held. Then Reset asserted mid-WAIT_VGA -> oVgaValid=0 and PC=0 immediately, without waiting for a clock edge.
- ROM[16'hFFFF] = STO -> PC wraps to 0. An undefined opcode consumes 2 cycles and produces no side effects.

Source files
------------

// File: rtl/instruction_sequencer_pkg.sv
// Shared opcodes, field positions, constants
// and state encoding for the sequencer.
package instruction_sequencer_pkg;

    localparam int OP_HI  = 27;
    localparam int OP_LO  = 24;
    localparam int A_HI   = 23;
    localparam int A_LO   = 16;
    localparam int B_HI   = 15;
    localparam int B_LO   = 0;
    localparam int CNT_HI = 23;
    localparam int VA_HI  = 15;
    localparam int VA_LO  = 8;
    localparam int VB_HI  = 7;
    localparam int VB_LO  = 0;
    localparam int LED_HI = 7;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STO = 4'h1;
    localparam logic [3:0] OP_VGA = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_LED = 4'h4;

    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    localparam logic [7:0] BLACK = 8'h00;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;
    localparam logic [7:0] WHITE = 8'hFF;

    localparam logic [1:0] ST_FETCH    = 2'd0;
    localparam logic [1:0] ST_DECODE   = 2'd1;
    localparam logic [1:0] ST_WAIT_NOP = 2'd2;
    localparam logic [1:0] ST_WAIT_VGA = 2'd3;

    typedef enum logic [1:0] {
        FETCH    = ST_FETCH,
        DECODE   = ST_DECODE,
        WAIT_NOP = ST_WAIT_NOP,
        WAIT_VGA = ST_WAIT_VGA
    } state_t;

    function automatic logic [27:0] mk_instr(
        input logic [3:0]  op,
        input logic [7:0]  a,
        input logic [15:0] b
    );
        return {op, a, b};
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// VGA draw request channel: the sequencer
// offers operands, the draw engine accepts.
interface instruction_sequencer_if;

    logic       oVgaValid;
    logic       iVgaReady;
    logic [7:0] oVgaColor;
    logic [7:0] oVgaRegA;
    logic [7:0] oVgaRegB;

    modport master (
        output oVgaValid,
        output oVgaColor,
        output oVgaRegA,
        output oVgaRegB,
        input  iVgaReady
    );

    modport slave (
        input  oVgaValid,
        input  oVgaColor,
        input  oVgaRegA,
        input  oVgaRegB,
        output iVgaReady
    );

endinterface

// File: rtl/instruction_sequencer_delay_counter.sv
// 24-bit loadable down-counter; done marks
// the last cycle of a NOP delay.
module instruction_sequencer_delay_counter (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        dec,
    output logic        done
);

    logic [23:0] cnt;

    // load wins over decrement; hold at zero
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt <= 24'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != 24'd0) begin
            cnt <= cnt - 24'd1;
        end
    end

    assign done = (cnt == 24'd1);

endmodule

// File: rtl/instruction_sequencer.sv
// Fetch/decode/execute controller driving
// the ROM address and all side effects.
import instruction_sequencer_pkg::*;

module instruction_sequencer (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iEnable,
    input  logic [27:0]             iInstruction,
    output logic [15:0]             oAddress,
    output logic                    oRegWrite,
    output logic [7:0]              oRegAddr,
    output logic [15:0]             oRegData,
    instruction_sequencer_if.master vga,
    output logic [7:0]              oLed
);

    state_t      state;
    logic [15:0] pc;
    logic [27:0] ir;
    logic [3:0]  op;
    logic [3:0]  in_op;
    logic [15:0] pc_inc;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_done;
    logic        nop_wait;

    assign op       = ir[OP_HI:OP_LO];
    assign in_op    = iInstruction[OP_HI:OP_LO];
    assign pc_inc   = pc + 16'd1;
    assign oAddress = pc;
    assign cnt_load = (state == DECODE)
                   && (op == OP_NOP);
    assign cnt_dec  = (state == WAIT_NOP);
    assign nop_wait = (op == OP_NOP)
                   && (ir[CNT_HI:0] != 24'd0);

    instruction_sequencer_delay_counter
      u_delay_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (cnt_load),
        .load_val (ir[CNT_HI:0]),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // VGA request is raised at capture so it is
    // already registered when DECODE begins
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state         <= FETCH;
            pc            <= 16'd0;
            ir            <= 28'd0;
            oRegWrite     <= 1'b0;
            oRegAddr      <= 8'd0;
            oRegData      <= 16'd0;
            oLed          <= 8'd0;
            vga.oVgaValid <= 1'b0;
            vga.oVgaColor <= 8'd0;
            vga.oVgaRegA  <= 8'd0;
            vga.oVgaRegB  <= 8'd0;
        end else begin
            oRegWrite <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (iEnable) begin
                        ir    <= iInstruction;
                        state <= DECODE;
                        if (in_op == OP_VGA) begin
                            vga.oVgaValid <= 1'b1;
                            vga.oVgaColor <=
                              iInstruction[A_HI:A_LO];
                            vga.oVgaRegA  <=
                              iInstruction[VA_HI:VA_LO];
                            vga.oVgaRegB  <=
                              iInstruction[VB_HI:VB_LO];
                        end
                    end
                end
                DECODE: begin
                    state <= FETCH;
                    unique case (1'b1)
                        (op == OP_STO): begin
                            oRegWrite <= 1'b1;
                            oRegAddr  <= ir[A_HI:A_LO];
                            oRegData  <= ir[B_HI:B_LO];
                            pc        <= pc_inc;
                        end
                        (op == OP_VGA): begin
                            if (vga.iVgaReady) begin
                                vga.oVgaValid <= 1'b0;
                                pc            <= pc_inc;
                            end else begin
                                state <= WAIT_VGA;
                            end
                        end
                        (op == OP_JMP): begin
                            pc <= ir[B_HI:B_LO];
                        end
                        (op == OP_LED): begin
                            oLed <= ir[LED_HI:0];
                            pc   <= pc_inc;
                        end
                        default: begin
                            if (nop_wait) begin
                                state <= WAIT_NOP;
                            end else begin
                                pc <= pc_inc;
                            end
                        end
                    endcase
                end
                WAIT_NOP: begin
                    if (cnt_done) begin
                        pc    <= pc_inc;
                        state <= FETCH;
                    end
                end
                WAIT_VGA: begin
                    if (vga.iVgaReady) begin
                        vga.oVgaValid <= 1'b0;
                        pc            <= pc_inc;
                        state         <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
